// File: rtl/pll_lock_reset_seq_pkg.sv
// Shared types for the PLL lock / domain reset sequencer.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package pll_rst_seq_pkg;

  // Encodings are visible on the debug state output, so keep them fixed.
  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_e;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/pll_lock_reset_seq_if.sv
// PLL/reset-sequencer signal bundle; slave = sequencer, master = PLL/system side.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface pll_lock_reset_seq_if #(
  parameter int NUM_DOMAINS = 5,
  parameter int RC_W        = 2
);
  logic                   locked_async;
  logic                   sw_reset_req;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_reset_n;
  logic                   lock_lost;
  logic                   fail;
  logic [RC_W-1:0]        retry_count;
  logic [2:0]             state;

  modport slave (
    input  locked_async, sw_reset_req,
    output pll_rst, domain_reset_n, lock_lost, fail, retry_count, state
  );

  modport master (
    output locked_async, sw_reset_req,
    input  pll_rst, domain_reset_n, lock_lost, fail, retry_count, state
  );
endinterface

// File: rtl/pll_lock_reset_seq_bit_sync.sv
// Generic N-stage single-bit synchronizer, resets to 0.
// Latency: STAGES clk cycles from a stable input to the output.
// Backpressure: none.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL reset driver, lock qualifier and ordered per-domain reset release.
// Latency: domain 0 released SYNC_STAGES+LOCK_STABLE_CYCLES (+-1) cycles after lock in WAIT_LOCK.
// Backpressure: none; sw_reset_req is a one-cycle pulse that preempts everything.
module pll_lock_reset_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS         = 5,
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGE_GAP_CYCLES    = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pll_lock_reset_seq_if.slave  bus
);
  localparam int PR_W = cnt_w(PLL_RST_CYCLES);
  localparam int ST_W = cnt_w(LOCK_STABLE_CYCLES);
  localparam int TO_W = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int GP_W = cnt_w(STAGE_GAP_CYCLES);
  localparam int RC_W = cnt_w(MAX_RETRIES);

  localparam logic [PR_W-1:0] PR_LAST    = PR_W'(PLL_RST_CYCLES - 1);
  localparam logic [ST_W-1:0] STABLE_MAX = ST_W'(LOCK_STABLE_CYCLES);
  localparam logic [TO_W-1:0] TMO_MAX    = TO_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [GP_W-1:0] GAP_LAST   = GP_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [RC_W-1:0] RETRY_MAX  = RC_W'(MAX_RETRIES);

  seq_state_e             r_state;
  logic [PR_W-1:0]        r_pr_cnt;
  logic [ST_W-1:0]        r_stable_cnt;
  logic [TO_W-1:0]        r_tmo_cnt;
  logic [GP_W-1:0]        r_gap_cnt;
  logic [RC_W-1:0]        r_retry;
  logic                   r_pll_rst;
  logic [NUM_DOMAINS-1:0] r_dom_rst_n;
  logic                   r_lock_lost;
  logic                   r_fail;

  logic                   w_locked_s;
  logic [ST_W-1:0]        w_stable_nxt;
  logic [TO_W-1:0]        w_tmo_nxt;
  logic [RC_W-1:0]        w_retry_nxt;
  logic                   w_qualify;
  logic                   w_timeout;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (bus.locked_async),
    .o_q     (w_locked_s)
  );

  // Saturating next values for the WAIT_LOCK counters and the retry count.
  always_comb begin
    w_stable_nxt = '0;
    if (w_locked_s)
      w_stable_nxt = (r_stable_cnt == STABLE_MAX) ? r_stable_cnt : r_stable_cnt + ST_W'(1);
    w_tmo_nxt   = (r_tmo_cnt == TMO_MAX) ? r_tmo_cnt : r_tmo_cnt + TO_W'(1);
    w_retry_nxt = (r_retry == RETRY_MAX) ? r_retry : r_retry + RC_W'(1);
    w_qualify   = (w_stable_nxt == STABLE_MAX);
    w_timeout   = (w_tmo_nxt == TMO_MAX);
  end

  // Sequencer FSM; every output is a flop so nothing glitches into the PLL or domains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_PLL_RST;
      r_pr_cnt     <= '0;
      r_stable_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_retry      <= '0;
      r_pll_rst    <= 1'b1;
      r_dom_rst_n  <= '0;
      r_lock_lost  <= 1'b0;
      r_fail       <= 1'b0;
    end else if (bus.sw_reset_req) begin
      r_state      <= ST_PLL_RST;
      r_pr_cnt     <= '0;
      r_stable_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_retry      <= '0;
      r_pll_rst    <= 1'b1;
      r_dom_rst_n  <= '0;
      r_lock_lost  <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          r_pll_rst   <= 1'b1;
          r_dom_rst_n <= '0;
          if (r_pr_cnt == PR_LAST) begin
            r_pr_cnt     <= '0;
            r_stable_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_pll_rst    <= 1'b0;
            r_state      <= ST_WAIT_LOCK;
          end else begin
            r_pr_cnt <= r_pr_cnt + PR_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          r_stable_cnt <= w_stable_nxt;
          r_tmo_cnt    <= w_tmo_nxt;
          // Qualification is checked first so it wins a same-cycle timeout.
          if (w_qualify) begin
            r_retry     <= '0;
            r_gap_cnt   <= '0;
            r_dom_rst_n <= NUM_DOMAINS'(1);
            r_state     <= ST_RELEASE;
          end else if (w_timeout) begin
            r_retry   <= w_retry_nxt;
            r_pll_rst <= 1'b1;
            r_pr_cnt  <= '0;
            if (w_retry_nxt == RETRY_MAX) begin
              r_fail  <= 1'b1;
              r_state <= ST_FAIL;
            end else begin
              r_state <= ST_PLL_RST;
            end
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!w_locked_s) begin
            r_dom_rst_n <= '0;
            r_lock_lost <= 1'b1;
            r_pll_rst   <= 1'b1;
            r_pr_cnt    <= '0;
            r_state     <= ST_PLL_RST;
          end else if (r_state == ST_RELEASE) begin
            // Released domains always form a contiguous run from bit 0, so shift in ones.
            if (r_dom_rst_n[NUM_DOMAINS-1]) begin
              r_state <= ST_RUN;
            end else if (r_gap_cnt == GAP_LAST) begin
              r_gap_cnt   <= '0;
              r_dom_rst_n <= (r_dom_rst_n << 1) | NUM_DOMAINS'(1);
            end else begin
              r_gap_cnt <= r_gap_cnt + GP_W'(1);
            end
          end
        end
        ST_FAIL: begin
          r_pll_rst   <= 1'b1;
          r_dom_rst_n <= '0;
          r_fail      <= 1'b1;
        end
        default: begin
          r_state <= ST_PLL_RST;
        end
      endcase
    end
  end

  assign bus.pll_rst        = r_pll_rst;
  assign bus.domain_reset_n = r_dom_rst_n;
  assign bus.lock_lost      = r_lock_lost;
  assign bus.fail           = r_fail;
  assign bus.retry_count    = r_retry;
  assign bus.state          = r_state;
endmodule
